// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        MD_RUN = 1'b1
    } pc_state_t;

    localparam int MD_TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use hazards, branch squash,
// multi-cycle MUL/DIV freeze with watchdog, and saturating perf counters.
//
// state  | meaning
// IDLE   | normal flow; load-use stall and branch flush are evaluated
// MD_RUN | MUL/DIV busy in E; F/D/E frozen, bubble into M, watchdog counting
module pipeline_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ResultSrcE0,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    input  logic             md_done,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             md_go,
    output logic             md_abort,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WD_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    pc_state_t       state, state_next;
    logic [WD_W-1:0] wd_cnt, wd_next;
    logic            lw_stall;
    logic            stall_f, stall_d, stall_e;
    logic            flush_d, flush_e, flush_m;
    logic            go, abort, err_set;

    assign lw_stall = ResultSrcE0 && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wd_cnt <= '0;
            md_err <= 1'b0;
        end else begin
            state  <= state_next;
            wd_cnt <= wd_next;
            if (err_set) begin
                md_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        wd_next    = wd_cnt;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        go         = 1'b0;
        abort      = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (MulDivE) begin
                    go         = 1'b1;
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    stall_e    = 1'b1;
                    flush_m    = 1'b1;
                    wd_next    = '0;
                    state_next = MD_RUN;
                end else begin
                    // a taken branch squashes the hazarding instr, so no stall is needed
                    stall_f = lw_stall && !PCSrcE;
                    stall_d = lw_stall && !PCSrcE;
                    flush_e = lw_stall || PCSrcE;
                    flush_d = PCSrcE;
                end
            end
            MD_RUN: begin
                if (md_done) begin
                    state_next = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    // watchdog: release E so the stuck instr retires rather than hanging the core
                    abort      = 1'b1;
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    wd_next = wd_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // outputs are combinational, so force them low while reset is held
    assign StallF   = rst && stall_f;
    assign StallD   = rst && stall_d;
    assign StallE   = rst && stall_e;
    assign FlushD   = rst && flush_d;
    assign FlushE   = rst && flush_e;
    assign FlushM   = rst && flush_m;
    assign md_go    = rst && go;
    assign md_abort = rst && abort;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (StallF),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (FlushD),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Scoreboard bench for pipeline_ctrl_unit: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipeline_ctrl_unit;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ResultSrcE0;
    logic [4:0]       RD_E, RS1_D, RS2_D;
    logic             PCSrcE, MulDivE, md_done;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic             md_go, md_abort, md_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [8:0]       bits;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ResultSrcE0 (ResultSrcE0),
        .RD_E        (RD_E),
        .RS1_D       (RS1_D),
        .RS2_D       (RS2_D),
        .PCSrcE      (PCSrcE),
        .MulDivE     (MulDivE),
        .md_done     (md_done),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .md_go       (md_go),
        .md_abort    (md_abort),
        .md_err      (md_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // bit order: StallF StallD StallE FlushD FlushE FlushM md_go md_abort md_err
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = sb.pop_front();
            act = {StallF, StallD, StallE, FlushD, FlushE, FlushM, md_go, md_abort, md_err};
            n_checks++;
            if (act !== e.bits) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.bits);
            end
            n_checks++;
            if (stall_cnt !== e.scnt) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.scnt);
            end
            n_checks++;
            if (flush_cnt !== e.fcnt) begin
                n_fail++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fcnt);
            end
        end
    end

    task automatic step(input logic r, input logic ld, input logic [4:0] rde,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic pcs,
                        input logic mde, input logic mdd, input logic [8:0] eb,
                        input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        ResultSrcE0 = ld;
        RD_E        = rde;
        RS1_D       = rs1;
        RS2_D       = rs2;
        PCSrcE      = pcs;
        MulDivE     = mde;
        md_done     = mdd;
        e.bits = eb;
        e.scnt = es;
        e.fcnt = ef;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b0; ResultSrcE0 = 1'b0; RD_E = '0; RS1_D = '0; RS2_D = '0;
        PCSrcE = 1'b0; MulDivE = 1'b0; md_done = 1'b0;

        step(0, 1, 5, 5, 0, 0, 1, 0, 9'b000000000, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 9'b000000000, 0, 0, "idle");
        step(1, 1, 5, 5, 0, 0, 0, 0, 9'b110010000, 0, 0, "lw_rs1");
        step(1, 1, 0, 0, 0, 0, 0, 0, 9'b000000000, 1, 0, "lw_x0");
        step(1, 1, 7, 3, 7, 0, 0, 0, 9'b110010000, 1, 0, "lw_rs2");
        step(1, 1, 7, 7, 0, 1, 0, 0, 9'b000110000, 2, 0, "br_over_lw");
        step(1, 0, 0, 0, 0, 1, 0, 0, 9'b000110000, 2, 1, "branch");
        step(1, 0, 5, 5, 0, 0, 0, 0, 9'b000000000, 2, 2, "alu_dep");

        step(1, 0, 0, 0, 0, 0, 1, 0, 9'b111001100, 2, 2, "md_go");
        for (int i = 0; i < 4; i++)
            step(1, i == 1, 5, 5, 0, i == 2, 1, 0, 9'b111001000, 4'(3 + i), 2, "md_run");
        step(1, 0, 0, 0, 0, 0, 1, 1, 9'b000000000, 7, 2, "md_done");
        step(1, 0, 0, 0, 0, 0, 1, 0, 9'b111001100, 7, 2, "md_b2b_go");
        step(1, 0, 0, 0, 0, 0, 1, 1, 9'b000000000, 8, 2, "md_b2b_done");
        step(1, 0, 0, 0, 0, 0, 0, 1, 9'b000000000, 8, 2, "done_in_idle");

        step(1, 0, 0, 0, 0, 0, 1, 0, 9'b111001100, 8, 2, "wd_go");
        for (int i = 0; i < 7; i++)
            step(1, 0, 0, 0, 0, 0, 1, 0, 9'b111001000, 4'(9 + i), 2, "wd_run");
        step(1, 0, 0, 0, 0, 0, 1, 0, 9'b000000010, 15, 2, "wd_abort");
        step(1, 0, 0, 0, 0, 0, 0, 0, 9'b000000001, 15, 2, "err_sticky");
        for (int i = 0; i < 4; i++)
            step(1, 1, 5, 5, 0, 0, 0, 0, 9'b110010001, 15, 2, "sat_stall");
        step(1, 0, 0, 0, 0, 0, 0, 0, 9'b000000001, 15, 2, "sat_hold");

        step(1, 0, 0, 0, 0, 0, 1, 0, 9'b111001101, 15, 2, "rst_go");
        step(0, 0, 0, 0, 0, 0, 1, 0, 9'b000000000, 0, 0, "rst_mid_run");
        step(1, 0, 0, 0, 0, 0, 0, 0, 9'b000000000, 0, 0, "post_rst_idle");
        step(1, 0, 0, 0, 0, 0, 1, 0, 9'b111001100, 0, 0, "post_rst_go");
        step(1, 0, 0, 0, 0, 0, 1, 1, 9'b000000000, 1, 0, "post_rst_done");

        for (int i = 0; i < 5 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
